// File: rtl/loader_pkg.sv
// Shared definitions for the CPU program loader: FSM states, header word
// slots and the memory address / count width.
package loader_pkg;

    localparam int ADDR_W = 16;

    // Slots of the two header words inside the latched header array
    localparam logic HDR_NI = 1'b0;
    localparam logic HDR_ND = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_D,
        ST_LOAD_I,
        ST_LOAD_D,
        ST_SETTLE,
        ST_RUN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that stops at LIMIT instead
// of wrapping.
module sat_counter #(
    parameter int         W     = 32,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Boot loader: streams a program image into the CPU's instruction and data
// memories, holds the CPU in reset while loading, then runs and supervises it.
module cpu_program_loader
    import loader_pkg::*;
#(
    parameter int               CNT_W      = 32,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [15:0]       s_data,
    output logic              ex_iwe,
    output logic [15:0]       ex_iaddr,
    output logic [15:0]       ex_idata,
    output logic              ex_dwe,
    output logic [15:0]       ex_daddr,
    output logic [15:0]       ex_ddata,
    output logic              cpu_rst_n,
    input  logic              cpu_done,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
);

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] hdr [2];
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              accept;
    logic              last_word;
    logic              limit_hit;
    logic              cyc_clr;
    logic              cyc_en;

    assign accept    = s_valid && s_ready;
    assign last_word = (remaining == 16'd1);
    assign limit_hit = (cycles == MAX_CYCLES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (accept) state_n = ST_HDR_D;
            end
            ST_HDR_D: begin
                // N_D arrives on s_data this cycle, N_I is already latched
                if (accept) begin
                    if (hdr[HDR_NI] != '0)  state_n = ST_LOAD_I;
                    else if (s_data != '0)  state_n = ST_LOAD_D;
                    else                    state_n = ST_SETTLE;
                end
            end
            ST_LOAD_I: begin
                if (accept && last_word)
                    state_n = (hdr[HDR_ND] != '0) ? ST_LOAD_D : ST_SETTLE;
            end
            ST_LOAD_D: begin
                if (accept && last_word) state_n = ST_SETTLE;
            end
            ST_SETTLE: state_n = ST_RUN;
            ST_RUN: begin
                if (cpu_done || limit_hit) state_n = ST_FIN;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            cpu_rst_n   <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            ex_iwe      <= 1'b0;
            ex_iaddr    <= '0;
            ex_idata    <= '0;
            ex_dwe      <= 1'b0;
            ex_daddr    <= '0;
            ex_ddata    <= '0;
            addr        <= '0;
            remaining   <= '0;
            hdr[HDR_NI] <= '0;
            hdr[HDR_ND] <= '0;
        end else begin
            s_ready   <= (state_n != ST_SETTLE) && (state_n != ST_RUN);
            busy      <= (state_n != ST_IDLE) && (state_n != ST_FIN);
            cpu_rst_n <= (state_n == ST_RUN);
            ex_iwe    <= 1'b0;
            ex_dwe    <= 1'b0;
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (accept) begin
                        hdr[HDR_NI] <= s_data;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end
                ST_HDR_D: begin
                    if (accept) begin
                        hdr[HDR_ND] <= s_data;
                        addr        <= '0;
                        remaining   <= (hdr[HDR_NI] != '0) ? hdr[HDR_NI] : s_data;
                    end
                end
                ST_LOAD_I: begin
                    if (accept) begin
                        ex_iwe   <= 1'b1;
                        ex_iaddr <= addr;
                        ex_idata <= s_data;
                        if (last_word) begin
                            addr      <= '0;
                            remaining <= hdr[HDR_ND];
                        end else begin
                            addr      <= addr + 1'b1;
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                ST_LOAD_D: begin
                    if (accept) begin
                        ex_dwe    <= 1'b1;
                        ex_daddr  <= addr;
                        ex_ddata  <= s_data;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                ST_RUN: begin
                    // A halt in the limit cycle wins over the timeout
                    if (cpu_done)       done    <= 1'b1;
                    else if (limit_hit) timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cyc_clr = accept && (state_q == ST_FIN);
    assign cyc_en  = (state_q == ST_RUN) && !cpu_done;

    sat_counter #(
        .W     (CNT_W),
        .LIMIT (MAX_CYCLES)
    ) u_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cyc_clr),
        .en    (cyc_en),
        .count (cycles)
    );

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed-plus-random bench for cpu_program_loader; write traffic is compared
// against the image the bench itself generated.
module tb_cpu_program_loader;

    localparam int MAXC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        ex_iwe;
    logic [15:0] ex_iaddr;
    logic [15:0] ex_idata;
    logic        ex_dwe;
    logic [15:0] ex_daddr;
    logic [15:0] ex_ddata;
    logic        cpu_rst_n;
    logic        cpu_done;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycles;

    int n_chk  = 0;
    int n_pass = 0;
    int both_cnt = 0;

    logic [31:0] iw_q[$];
    logic [31:0] dw_q[$];
    logic [15:0] exp_i[$];
    logic [15:0] exp_d[$];

    cpu_program_loader #(
        .CNT_W      (32),
        .MAX_CYCLES (32'(MAXC))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .ex_iwe    (ex_iwe),
        .ex_iaddr  (ex_iaddr),
        .ex_idata  (ex_idata),
        .ex_dwe    (ex_dwe),
        .ex_daddr  (ex_daddr),
        .ex_ddata  (ex_ddata),
        .cpu_rst_n (cpu_rst_n),
        .cpu_done  (cpu_done),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    // Each strobe lasts exactly one cycle, so sampling mid-cycle logs it once
    always @(negedge clk) begin
        if (ex_iwe) iw_q.push_back({ex_iaddr, ex_idata});
        if (ex_dwe) dw_q.push_back({ex_daddr, ex_ddata});
        if (ex_iwe && ex_dwe) both_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted
    task automatic send(input logic [15:0] w, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = w;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
    endtask

    function automatic int pick_gap(input int gmax);
        return (gmax == 0) ? 0 : int'($urandom_range(gmax, 0));
    endfunction

    task automatic send_image(input int ni, input int nd, input int gmax, input bit chk_restart);
        logic [15:0] w;
        exp_i.delete(); exp_d.delete(); iw_q.delete(); dw_q.delete();
        send(16'(ni), pick_gap(gmax));
        if (chk_restart) begin
            chk("restart_done", {31'd0, done}, 32'd0);
            chk("restart_timeout", {31'd0, timeout}, 32'd0);
            chk("restart_cycles", cycles, 32'd0);
            chk("restart_busy", {31'd0, busy}, 32'd1);
        end
        send(16'(nd), pick_gap(gmax));
        for (int i = 0; i < ni; i++) begin
            w = 16'($urandom);
            exp_i.push_back(w);
            send(w, pick_gap(gmax));
        end
        for (int i = 0; i < nd; i++) begin
            w = 16'($urandom);
            exp_d.push_back(w);
            send(w, pick_gap(gmax));
        end
        s_valid = 1'b0;
    endtask

    // Expected: memory k holds payload word k, one strobe per word, in order
    task automatic check_writes(input string tag);
        logic [31:0] obs;
        chk({tag, "_icount"}, 32'(iw_q.size()), 32'(exp_i.size()));
        chk({tag, "_dcount"}, 32'(dw_q.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_i.size(); i++) begin
            obs = (i < iw_q.size()) ? iw_q[i] : 32'hDEAD_BEEF;
            chk({tag, "_iwrite"}, obs, {16'(i), exp_i[i]});
        end
        for (int i = 0; i < exp_d.size(); i++) begin
            obs = (i < dw_q.size()) ? dw_q[i] : 32'hDEAD_BEEF;
            chk({tag, "_dwrite"}, obs, {16'(i), exp_d[i]});
        end
    endtask

    // Called at the first RUN negedge: r counted cycles, then halt or limit
    task automatic run_check(input string tag, input int r, input bit use_done);
        for (int i = 0; i < r; i++) begin
            cpu_done = 1'b0;
            @(negedge clk);
        end
        cpu_done = use_done;
        @(negedge clk);
        cpu_done = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, {31'd0, use_done});
        chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, !use_done});
        chk({tag, "_cycles"}, cycles, 32'(r));
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, s_ready}, 32'd1);
        repeat (2) @(negedge clk);
        chk({tag, "_cycles_hold"}, cycles, 32'(r));
    endtask

    initial begin
        int ni;
        int nd;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        cpu_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        chk("rst_we", {30'd0, ex_iwe, ex_dwe}, 32'd0);
        chk("rst_addr", {ex_iaddr, ex_daddr}, 32'd0);
        chk("rst_data", {ex_idata, ex_ddata}, 32'd0);
        chk("rst_flags", {30'd0, done, timeout}, 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 3 instructions + 2 data words, valid held high throughout
        send_image(3, 2, 0, 1'b0);
        chk("t1_last_dwe", {31'd0, ex_dwe}, 32'd1);
        chk("t1_last_daddr", {16'd0, ex_daddr}, 32'd1);
        chk("t1_last_ddata", {16'd0, ex_ddata}, {16'd0, exp_d[1]});
        chk("t1_settle_ready", {31'd0, s_ready}, 32'd0);
        chk("t1_settle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk);
        chk("t1_run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        chk("t1_run_dwe_low", {31'd0, ex_dwe}, 32'd0);
        chk("t1_run_busy", {31'd0, busy}, 32'd1);
        check_writes("t1");
        run_check("t1_run", 4, 1'b1);

        // Empty image, restarted from FIN
        send_image(0, 0, 0, 1'b1);
        chk("t2_settle_ready", {31'd0, s_ready}, 32'd0);
        chk("t2_settle_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk);
        chk("t2_run_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        check_writes("t2");
        run_check("t2_run", 5, 1'b1);

        // Random sizes, data and valid gaps; then run into the cycle limit
        ni = int'($urandom_range(12, 4));
        nd = int'($urandom_range(10, 3));
        send_image(ni, nd, 3, 1'b1);
        @(negedge clk);
        check_writes("t3");
        run_check("t3_timeout", MAXC, 1'b0);

        // Halt arrives in the same cycle the limit is reached
        send_image(1, 1, 0, 1'b1);
        @(negedge clk);
        check_writes("t4");
        run_check("t4_tie", MAXC, 1'b1);

        // Reset in the middle of the data phase, then a fresh image
        exp_i.delete(); exp_d.delete();
        send(16'd2, 0);
        send(16'd3, 0);
        send(16'h1111, 0);
        send(16'h2222, 0);
        send(16'h3333, 0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("t5_rst_we", {30'd0, ex_iwe, ex_dwe}, 32'd0);
        chk("t5_rst_addr", {ex_iaddr, ex_daddr}, 32'd0);
        chk("t5_rst_data", {ex_idata, ex_ddata}, 32'd0);
        chk("t5_rst_ready", {31'd0, s_ready}, 32'd1);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_flags", {29'd0, cpu_rst_n, done, timeout}, 32'd0);
        chk("t5_rst_cycles", cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_image(1, 2, 2, 1'b0);
        @(negedge clk);
        check_writes("t5");
        run_check("t5_run", 3, 1'b1);

        chk("strobes_exclusive", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
